// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, sizes and coefficient table for the 64-tap FIR
package fir_pkg;

    localparam int TAPS = 64;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int OW   = DW + CW + $clog2(TAPS);
    localparam int IW   = $clog2(TAPS);

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [CW-1:0] coeff_t;
    typedef logic signed [OW-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    // Linear ramp from +512 down to -496 in steps of 16; h[0] meets the newest sample.
    localparam coeff_t COEFFS [0:TAPS-1] = '{
         16'sd512,  16'sd496,  16'sd480,  16'sd464,  16'sd448,  16'sd432,  16'sd416,  16'sd400,
         16'sd384,  16'sd368,  16'sd352,  16'sd336,  16'sd320,  16'sd304,  16'sd288,  16'sd272,
         16'sd256,  16'sd240,  16'sd224,  16'sd208,  16'sd192,  16'sd176,  16'sd160,  16'sd144,
         16'sd128,  16'sd112,   16'sd96,   16'sd80,   16'sd64,   16'sd48,   16'sd32,   16'sd16,
           16'sd0,  -16'sd16,  -16'sd32,  -16'sd48,  -16'sd64,  -16'sd80,  -16'sd96, -16'sd112,
        -16'sd128, -16'sd144, -16'sd160, -16'sd176, -16'sd192, -16'sd208, -16'sd224, -16'sd240,
        -16'sd256, -16'sd272, -16'sd288, -16'sd304, -16'sd320, -16'sd336, -16'sd352, -16'sd368,
        -16'sd384, -16'sd400, -16'sd416, -16'sd432, -16'sd448, -16'sd464, -16'sd480, -16'sd496
    };

endpackage

// File: rtl/fir_coeff_rom.sv
// rtl/fir_coeff_rom.sv - combinational coefficient lookup by tap index
module fir_coeff_rom
    import fir_pkg::*;
#(
    parameter bit     COEFF_OVERRIDE = 1'b0,
    parameter coeff_t OVERRIDE_VALUE = '0
) (
    input  logic [IW-1:0]        idx,
    output logic signed [CW-1:0] coeff
);

    // The override replaces every tap with one value so full-scale corners can be exercised.
    assign coeff = COEFF_OVERRIDE ? OVERRIDE_VALUE : COEFFS[idx];

endmodule

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - sequential 64-tap FIR with a single time-shared MAC
module fir_filter
    import fir_pkg::*;
#(
    parameter bit     COEFF_OVERRIDE = 1'b0,
    parameter coeff_t OVERRIDE_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] FIR_input,
    input  logic                 input_valid,
    output logic signed [OW-1:0] FIR_output,
    output logic                 output_valid
);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    sample_t         delay [0:TAPS-1];
    acc_t            acc;
    coeff_t          coeff;
    logic signed [DW+CW-1:0] prod;
    acc_t            prod_ext;

    fir_coeff_rom #(
        .COEFF_OVERRIDE (COEFF_OVERRIDE),
        .OVERRIDE_VALUE (OVERRIDE_VALUE)
    ) u_rom (
        .idx   (idx),
        .coeff (coeff)
    );

    // Full-precision product, sign-extended so 64 worst-case terms cannot wrap.
    assign prod     = delay[idx] * coeff;
    assign prod_ext = acc_t'(prod);

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept in IDLE, run TAPS MAC cycles, one publish cycle, back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (input_valid) state_nxt = MAC;
            MAC:  if (idx == IW'(TAPS - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line, accumulator, tap index and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) delay[k] <= '0;
            acc          <= '0;
            idx          <= '0;
            FIR_output   <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) delay[k] <= delay[k-1];
                        delay[0] <= FIR_input;
                        acc      <= '0;
                        idx      <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + IW'(1);
                end
                DONE: begin
                    FIR_output   <= acc;
                    output_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - directed self-checking bench for fir_filter
module tb_fir_filter;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] fir_input;
    logic               input_valid;
    logic signed [37:0] fir_output;
    logic               output_valid;
    logic signed [37:0] fir_output_ext;
    logic               output_valid_ext;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint hist [0:63];
    longint exp_out, exp_ext, got_out, got_ext;
    int     lat, pulses;

    always #5 clk = ~clk;

    fir_filter dut (
        .clk          (clk),
        .rst          (rst),
        .FIR_input    (fir_input),
        .input_valid  (input_valid),
        .FIR_output   (fir_output),
        .output_valid (output_valid)
    );

    fir_filter #(
        .COEFF_OVERRIDE (1'b1),
        .OVERRIDE_VALUE (-16'sd32768)
    ) dut_ext (
        .clk          (clk),
        .rst          (rst),
        .FIR_input    (fir_input),
        .input_valid  (input_valid),
        .FIR_output   (fir_output_ext),
        .output_valid (output_valid_ext)
    );

    function automatic longint h_ref(input int k);
        return 512 - 16 * k;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        input_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) hist[k] = 0;
    endtask

    // Presents one sample for 'hold' edges and watches 100 edges for result pulses.
    task automatic run_sample(input longint s, input int hold);
        for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        exp_out = 0;
        exp_ext = 0;
        for (int k = 0; k < 64; k++) begin
            exp_out += h_ref(k) * hist[k];
            exp_ext += -32768 * hist[k];
        end
        @(negedge clk);
        fir_input   = 16'(s);
        input_valid = 1'b1;
        lat    = -1;
        pulses = 0;
        got_out = 0;
        got_ext = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n + 1 >= hold) input_valid = 1'b0;
            if (output_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat     = n;
                    got_out = fir_output;
                    got_ext = fir_output_ext;
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        fir_input   = '0;
        input_valid = 1'b0;

        // 1. reset state
        do_reset();
        check("reset_out", fir_output, 0);
        check("reset_valid", longint'(output_valid), 0);

        // 2. first sample with strobe held across two edges
        run_sample(293, 2);
        check("first_latency", lat, 65);
        check("first_pulses", pulses, 1);
        check("first_value", got_out, 150016);
        check("first_model", got_out, exp_out);
        repeat (20) @(negedge clk);
        check("hold_stable", fir_output, 150016);
        check("hold_valid_low", longint'(output_valid), 0);

        // 3. short sequence against the convolution model
        run_sample(3601, 1);
        check("seq2_value", got_out, 1989040);
        check("seq2_pulses", pulses, 1);
        run_sample(2205, 1);
        check("seq3_model", got_out, exp_out);
        run_sample(-1696, 1);
        check("seq4_model", got_out, exp_out);
        run_sample(-2502, 2);
        check("seq5_model", got_out, exp_out);
        check("seq5_latency", lat, 65);

        // 4. impulse response reproduces the coefficient table
        do_reset();
        for (int i = 0; i < 65; i++) begin
            run_sample((i == 0) ? 1 : 0, 1);
            if (i < 64) check($sformatf("impulse_h%0d", i), got_out, h_ref(i));
            else        check("impulse_tail", got_out, 0);
        end

        // 5. full-scale extremes on the overridden-coefficient instance
        do_reset();
        for (int i = 0; i < 64; i++) begin
            run_sample(-32768, 1);
            if (i == 0)  check("ext_first", got_ext, 64'sd1073741824);
            if (i == 63) begin
                check("ext_full", got_ext, 64'sd68719476736);
                check("ext_model", got_ext, exp_ext);
                check("ext_ramp", got_out, -16777216);
            end
        end

        // 6. reset in the middle of a computation
        do_reset();
        @(negedge clk);
        fir_input   = 16'sd1000;
        input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) hist[k] = 0;
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (output_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_out_zero", fir_output, 0);
        run_sample(7, 1);
        check("after_abort_value", got_out, 3584);
        check("after_abort_latency", lat, 65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
